// File: rtl/game_pkg.sv
// Shared types and constants for the game-state UART transmitter.
// Build option GAME_TX_CHECKSUM_EN appends an XOR checksum byte to each frame.
package game_pkg;

    localparam int         COORD_W   = 6;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef GAME_TX_CHECKSUM_EN
    localparam int NBYTES = 6;
`else
    localparam int NBYTES = 5;
`endif

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 UART byte serialiser with bit timer; a start request seen in the last
// stop-bit cycle chains the next byte with no idle gap.
module uart_byte_tx
    import game_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       txd_o,
    output logic       ready_o,
    output logic       done_o
);

    localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);

    tx_state_e   state_q, state_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tick;

    assign tick    = (clk_cnt_q == LAST_TICK);
    assign ready_o = (state_q == IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = tick ? '0 : clk_cnt_q + 16'd1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        txd_o     = 1'b1;
        done_o    = 1'b0;
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (start_i) begin
                    shift_d = data_i;
                    state_d = START;
                end
            end
            START: begin
                txd_o = 1'b0;
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                txd_o = shift_q[0];
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                    else                   bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    done_o = 1'b1;
                    if (start_i) begin
                        shift_d = data_i;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/game_state_uart_tx.sv
// Snapshots the four game coordinates and streams them as one UART frame:
// sync, pac_x, pac_y, ghost_x, ghost_y [, checksum if GAME_TX_CHECKSUM_EN].
module game_state_uart_tx
    import game_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_send,
    input  logic [COORD_W-1:0] i_pac_x,
    input  logic [COORD_W-1:0] i_pac_y,
    input  logic [COORD_W-1:0] i_ghost_x,
    input  logic [COORD_W-1:0] i_ghost_y,
    output logic               o_txd,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

    logic [COORD_W-1:0] pac_x_q, pac_y_q, ghost_x_q, ghost_y_q;
    logic [COORD_W-1:0] pac_x_d, pac_y_d, ghost_x_d, ghost_y_d;
    logic [2:0]         idx_q, idx_d;
    logic               byte_start, byte_ready, byte_done, last_byte;
    logic [7:0]         byte_data;

    function automatic logic [7:0] ext(input logic [COORD_W-1:0] c);
        return {{(8 - COORD_W){1'b0}}, c};
    endfunction

    assign last_byte = (idx_q == LAST_IDX);
    assign o_busy    = !byte_ready;
    assign o_done    = byte_done && last_byte;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pac_x_q   <= '0;
            pac_y_q   <= '0;
            ghost_x_q <= '0;
            ghost_y_q <= '0;
            idx_q     <= '0;
        end else begin
            pac_x_q   <= pac_x_d;
            pac_y_q   <= pac_y_d;
            ghost_x_q <= ghost_x_d;
            ghost_y_q <= ghost_y_d;
            idx_q     <= idx_d;
        end
    end

    // While idle the next byte is always sync; mid-frame it is the one after idx_q.
    always_comb begin
        pac_x_d    = pac_x_q;
        pac_y_d    = pac_y_q;
        ghost_x_d  = ghost_x_q;
        ghost_y_d  = ghost_y_q;
        idx_d      = idx_q;
        byte_start = 1'b0;
        byte_data  = SYNC_BYTE;
        if (byte_ready) begin
            byte_start = i_send;
            if (i_send) begin
                pac_x_d   = i_pac_x;
                pac_y_d   = i_pac_y;
                ghost_x_d = i_ghost_x;
                ghost_y_d = i_ghost_y;
                idx_d     = '0;
            end
        end else begin
            byte_start = !last_byte;
            case (idx_q + 3'd1)
                3'd1:    byte_data = ext(pac_x_q);
                3'd2:    byte_data = ext(pac_y_q);
                3'd3:    byte_data = ext(ghost_x_q);
                3'd4:    byte_data = ext(ghost_y_q);
`ifdef GAME_TX_CHECKSUM_EN
                3'd5:    byte_data = ext(pac_x_q) ^ ext(pac_y_q) ^ ext(ghost_x_q) ^ ext(ghost_y_q);
`endif
                default: byte_data = SYNC_BYTE;
            endcase
            if (byte_done && !last_byte) idx_d = idx_q + 3'd1;
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .start_i (byte_start),
        .data_i  (byte_data),
        .txd_o   (o_txd),
        .ready_o (byte_ready),
        .done_o  (byte_done)
    );

endmodule

// File: tb/tb_game_state_uart_tx.sv
// Directed and randomized checks of game_state_uart_tx against a frame-level
// reference model of the expected serial waveform.
module tb_game_state_uart_tx;

    localparam int CPB = 4;
`ifdef GAME_TX_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif
    localparam int FRAME = NB * 10 * CPB;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       send  = 1'b0;
    logic [5:0] px = '0, py = '0, gx = '0, gy = '0;
    logic       txd, busy, done;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic [7:0] exp_bytes [6];

    game_state_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_send    (send),
        .i_pac_x   (px),
        .i_pac_y   (py),
        .i_ghost_x (gx),
        .i_ghost_y (gy),
        .o_txd     (txd),
        .o_busy    (busy),
        .o_done    (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic act, input logic exp);
        checks++;
        assert (act === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, act, exp);
        end
    endtask

    function automatic void build_frame(input logic [5:0] a, b, c, d);
        exp_bytes[0] = 8'hA5;
        exp_bytes[1] = {2'b00, a};
        exp_bytes[2] = {2'b00, b};
        exp_bytes[3] = {2'b00, c};
        exp_bytes[4] = {2'b00, d};
        exp_bytes[5] = {2'b00, a ^ b ^ c ^ d};
    endfunction

    // Line level k cycles after the first start-bit cycle.
    function automatic logic exp_txd(input int k);
        int byte_i = k / (10 * CPB);
        int bit_i  = (k % (10 * CPB)) / CPB;
        if (bit_i == 0) return 1'b0;
        if (bit_i == 9) return 1'b1;
        return exp_bytes[byte_i][bit_i - 1];
    endfunction

    task automatic start_frame(input logic [5:0] a, b, c, d);
        px = a; py = b; gx = c; gy = d;
        build_frame(a, b, c, d);
        send = 1'b1;
        tick();
    endtask

    task automatic check_frame(input string tag, input int poke_at, input bit keep_send);
        for (int k = 0; k < FRAME; k++) begin
            chk($sformatf("%s txd k=%0d", tag, k), txd, exp_txd(k));
            chk($sformatf("%s busy k=%0d", tag, k), busy, 1'b1);
            chk($sformatf("%s done k=%0d", tag, k), done, k == FRAME - 1);
            if (k == 0 && !keep_send) send = 1'b0;
            if (k == poke_at) begin
                send = 1'b1;
                px = 6'($urandom); py = 6'($urandom);
                gx = 6'($urandom); gy = 6'($urandom);
            end
            if (poke_at >= 0 && k == poke_at + 1) send = 1'b0;
            tick();
        end
        chk({tag, " idle txd"}, txd, 1'b1);
        chk({tag, " idle busy"}, busy, 1'b0);
        chk({tag, " idle done"}, done, 1'b0);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst txd", txd, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            chk("idle txd", txd, 1'b1);
            chk("idle busy", busy, 1'b0);
            chk("idle done", done, 1'b0);
            tick();
        end

        start_frame(6'd4, 6'd4, 6'd0, 6'd0);
        check_frame("f4400", -1, 1'b0);

        start_frame(6'h3F, 6'd1, 6'd2, 6'd3);
        check_frame("f3F123", -1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            start_frame(6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));
            check_frame($sformatf("rand%0d", r), -1, 1'b0);
        end

        start_frame(6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));
        check_frame("poke", 50, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk("noqueue busy", busy, 1'b0);
            chk("noqueue txd", txd, 1'b1);
            tick();
        end

        start_frame(6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));
        send = 1'b0;
        repeat (30) tick();
        rst_n = 1'b0;
        #1;
        chk("abort txd", txd, 1'b1);
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("inrst txd", txd, 1'b1);
            chk("inrst busy", busy, 1'b0);
            chk("inrst done", done, 1'b0);
        end
        rst_n = 1'b1;
        tick();
        start_frame(6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));
        check_frame("afterrst", -1, 1'b0);

        start_frame(6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));
        check_frame("hold1", -1, 1'b1);
        tick();
        check_frame("hold2", -1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
